// File: rtl/ntt_mlkem_masked_mult_sched_if.sv
// Bundle between the masked-multiplier issue scheduler and its surroundings
// (two requesters, PRNG, pipelined multiplier, NTT controller).
//   master : drives requests, randomness status, multiplier result, flush/zeroize
//   slave  : the scheduler; drives readies, operand registers, responses, status
interface ntt_mlkem_masked_mult_sched_if #(
    parameter int WIDTH        = 24,
    parameter int MULT_LATENCY = 8,
    parameter int TAG_W        = 8
);
    localparam int CNT_W = $clog2(MULT_LATENCY + 2);

    logic                      zeroize;

    logic                      req0_valid;
    logic                      req0_ready;
    logic [1:0][WIDTH-1:0]     req0_u;
    logic [1:0][WIDTH-1:0]     req0_v;
    logic [TAG_W-1:0]          req0_tag;

    logic                      req1_valid;
    logic                      req1_ready;
    logic [1:0][WIDTH-1:0]     req1_u;
    logic [1:0][WIDTH-1:0]     req1_v;
    logic [TAG_W-1:0]          req1_tag;

    logic                      rnd_valid;
    logic                      rnd_consume;

    logic [1:0][WIDTH-1:0]     mult_u;
    logic [1:0][WIDTH-1:0]     mult_v;
    logic [1:0][WIDTH-1:0]     mult_res;

    logic                      rsp0_valid;
    logic                      rsp1_valid;
    logic [TAG_W-1:0]          rsp_tag;
    logic [1:0][WIDTH-1:0]     rsp_res;

    logic                      flush_req;
    logic                      flush_done;
    logic                      busy;
    logic [CNT_W-1:0]          inflight;

    modport master (
        output zeroize,
        output req0_valid, req0_u, req0_v, req0_tag,
        input  req0_ready,
        output req1_valid, req1_u, req1_v, req1_tag,
        input  req1_ready,
        output rnd_valid,
        input  rnd_consume,
        input  mult_u, mult_v,
        output mult_res,
        input  rsp0_valid, rsp1_valid, rsp_tag, rsp_res,
        output flush_req,
        input  flush_done, busy, inflight
    );

    modport slave (
        input  zeroize,
        input  req0_valid, req0_u, req0_v, req0_tag,
        output req0_ready,
        input  req1_valid, req1_u, req1_v, req1_tag,
        output req1_ready,
        input  rnd_valid,
        output rnd_consume,
        output mult_u, mult_v,
        input  mult_res,
        output rsp0_valid, rsp1_valid, rsp_tag, rsp_res,
        input  flush_req,
        output flush_done, busy, inflight
    );
endinterface

// File: rtl/ntt_mlkem_masked_mult_sched.sv
// Issue scheduler for the two-share masked ML-KEM multiplier.
// Round-robin arbitrates the BFU (req0) and pointwise (req1) paths onto one
// fixed-latency multiplier, issues only when fresh randomness is present,
// tracks owner/tag through a shadow pipe and returns results to the owner.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : requests/readies, randomness, multiplier operands/result,
//                  responses, flush handshake, zeroize, busy/inflight status
module ntt_mlkem_masked_mult_sched #(
    parameter int WIDTH        = 24,
    parameter int MULT_LATENCY = 8,
    parameter int TAG_W        = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    ntt_mlkem_masked_mult_sched_if.slave   bus
);
    localparam int CNT_W = $clog2(MULT_LATENCY + 2);
    localparam int LAST  = MULT_LATENCY;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                     state;
    logic                       last_grant;
    logic [LAST:0]              vld_pipe;
    logic [LAST:0]              own_pipe;
    logic [LAST:0][TAG_W-1:0]   tag_pipe;
    logic [CNT_W-1:0]           inflight_q;
    logic [1:0][WIDTH-1:0]      mult_u_q;
    logic [1:0][WIDTH-1:0]      mult_v_q;
    logic                       flush_done_q;

    logic                       issue;
    logic                       grant;
    logic                       retire;
    logic                       drain_empty;
    logic [TAG_W-1:0]           sel_tag;
    logic [1:0][WIDTH-1:0]      sel_u;
    logic [1:0][WIDTH-1:0]      sel_v;
    logic [CNT_W-1:0]           inc;
    logic [CNT_W-1:0]           dec;

    always_comb begin
        // reset_n is folded in so readies stay low while reset is held,
        // even with requests and randomness present.
        issue = reset_n & ~bus.zeroize & bus.rnd_valid & (state != DRAIN)
              & (bus.req0_valid | bus.req1_valid);
        // Requester 1 wins when alone, or when both ask and 0 won last time.
        grant   = bus.req1_valid & (~bus.req0_valid | ~last_grant);
        sel_tag = grant ? bus.req1_tag : bus.req0_tag;
        sel_u   = grant ? bus.req1_u   : bus.req0_u;
        sel_v   = grant ? bus.req1_v   : bus.req0_v;
        retire  = vld_pipe[LAST];
        inc     = {{(CNT_W-1){1'b0}}, issue};
        dec     = {{(CNT_W-1){1'b0}}, retire};
        // Counter will be zero next cycle (no issue is possible in DRAIN);
        // looking ahead one cycle keeps the flush_done latency bounded.
        drain_empty = (inflight_q == '0)
                    | ((inflight_q == CNT_W'(1)) & retire);
    end

    assign bus.req0_ready  = issue & ~grant;
    assign bus.req1_ready  = issue &  grant;
    assign bus.rnd_consume = issue;
    assign bus.mult_u      = mult_u_q;
    assign bus.mult_v      = mult_v_q;
    // Results of operations killed by zeroize in this same cycle are dropped.
    assign bus.rsp0_valid  = retire & ~own_pipe[LAST] & ~bus.zeroize;
    assign bus.rsp1_valid  = retire &  own_pipe[LAST] & ~bus.zeroize;
    assign bus.rsp_tag     = tag_pipe[LAST];
    assign bus.rsp_res     = bus.mult_res;
    assign bus.flush_done  = flush_done_q;
    assign bus.busy        = (inflight_q != '0) | (state == DRAIN);
    assign bus.inflight    = inflight_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            vld_pipe     <= '0;
            own_pipe     <= '0;
            tag_pipe     <= '0;
            inflight_q   <= '0;
            mult_u_q     <= '0;
            mult_v_q     <= '0;
            flush_done_q <= 1'b0;
        end else if (bus.zeroize) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            vld_pipe     <= '0;
            own_pipe     <= '0;
            tag_pipe     <= '0;
            inflight_q   <= '0;
            mult_u_q     <= '0;
            mult_v_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            // Shadow pipe mirrors the multiplier: stage 0 lines up with the
            // operand registers, stage LAST with mult_res.
            vld_pipe   <= {vld_pipe[LAST-1:0], issue};
            own_pipe   <= {own_pipe[LAST-1:0], issue & grant};
            tag_pipe   <= {tag_pipe[LAST-1:0], issue ? sel_tag : {TAG_W{1'b0}}};
            // Zero shares on idle cycles so no share is presented twice.
            mult_u_q   <= issue ? sel_u : '0;
            mult_v_q   <= issue ? sel_v : '0;
            if (issue)
                last_grant <= grant;
            inflight_q   <= inflight_q + inc - dec;
            flush_done_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.flush_req)  state <= DRAIN;
                    else if (issue)     state <= ACTIVE;
                end
                ACTIVE: begin
                    if (bus.flush_req)               state <= DRAIN;
                    else if (!issue && drain_empty)  state <= IDLE;
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state        <= IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
